// File: rtl/mem_rot_reader.sv
// Rotating read controller for the dual-read polynomial memory.
// Streams DEPTH words, each a WIDTH-bit window that starts at bit
// (word_off+k)*WIDTH + bit_off of the cyclic polynomial.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; FIFO empty, no reads in flight
// S_RUN  | issuing read pairs and draining the output FIFO
// S_FIN  | one-cycle done pulse, then back to S_IDLE
module mem_rot_reader #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 70,
  parameter int AW    = $clog2(DEPTH),
  parameter int BW    = $clog2(WIDTH)
) (
  input  logic             i_clock,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [AW-1:0]    i_word_off,
  input  logic [BW-1:0]    i_bit_off,
  output logic             o_busy,
  output logic             o_done,
  output logic [AW-1:0]    o_rd_addr_0,
  output logic [AW-1:0]    o_rd_addr_1,
  input  logic [WIDTH-1:0] i_rd_q_0,
  input  logic [WIDTH-1:0] i_rd_q_1,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_last
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [BW-1:0]    r_bit_off;
  logic [AW-1:0]    r_rd_addr_0;
  logic [AW-1:0]    r_rd_addr_1;
  logic [CW-1:0]    r_issue_cnt;
  logic [CW-1:0]    r_out_cnt;
  logic [1:0]       r_credit;
  logic             r_inflight;
  logic [WIDTH-1:0] r_fifo [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_fifo_cnt;

  logic             w_start_acc;
  logic             w_hs;
  logic             w_issue;
  logic             w_push;
  logic [WIDTH-1:0] w_shifted;
  logic [AW-1:0]    w_start_addr_1;
  logic [AW-1:0]    w_next_addr_0;
  logic [AW-1:0]    w_next_addr_1;

  assign w_start_acc = (r_state == S_IDLE) && i_start;
  assign o_out_valid = (r_fifo_cnt != 2'd0);
  assign o_out_data  = r_fifo[r_rd_ptr];
  assign o_out_last  = o_out_valid && (r_out_cnt == LAST_IDX);
  assign w_hs        = o_out_valid && i_out_ready;
  // A full credit window can still issue when a word leaves this cycle.
  assign w_issue     = (r_state == S_RUN) && (r_issue_cnt < DEPTH_C) &&
                       ((r_credit != 2'd2) || w_hs);
  // Memory data lags the issue by one cycle.
  assign w_push      = r_inflight;
  assign w_shifted   = WIDTH'({i_rd_q_1, i_rd_q_0} >> r_bit_off);

  // Wrap by compare so non-power-of-two depths work.
  assign w_start_addr_1 = (i_word_off  == LAST_ADDR) ? '0 : i_word_off  + 1'b1;
  assign w_next_addr_0  = (r_rd_addr_0 == LAST_ADDR) ? '0 : r_rd_addr_0 + 1'b1;
  assign w_next_addr_1  = (r_rd_addr_1 == LAST_ADDR) ? '0 : r_rd_addr_1 + 1'b1;

  assign o_rd_addr_0 = r_rd_addr_0;
  assign o_rd_addr_1 = r_rd_addr_1;

  // State register.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_RUN;
      S_RUN: begin
        o_busy = 1'b1;
        if (w_hs && o_out_last) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Offset latch and read address generation.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_off   <= '0;
      r_rd_addr_0 <= '0;
      r_rd_addr_1 <= '0;
      r_issue_cnt <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_start_acc) begin
        r_bit_off   <= i_bit_off;
        r_rd_addr_0 <= i_word_off;
        r_rd_addr_1 <= w_start_addr_1;
        r_issue_cnt <= '0;
      end else if (w_issue) begin
        r_rd_addr_0 <= w_next_addr_0;
        r_rd_addr_1 <= w_next_addr_1;
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
    end
  end

  // Credit tracks FIFO occupancy plus the read in flight.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credit <= 2'd0;
    end else begin
      case ({w_issue, w_hs})
        2'b10:   r_credit <= r_credit + 2'd1;
        2'b01:   r_credit <= r_credit - 2'd1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  // Two-entry output FIFO holding shifted words.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_shifted;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_hs) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_hs})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Output word index, used to flag the final word.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n)         r_out_cnt <= '0;
    else if (w_start_acc) r_out_cnt <= '0;
    else if (w_hs)        r_out_cnt <= r_out_cnt + 1'b1;
  end

endmodule

// File: tb/tb_mem_rot_reader.sv
// Directed bench: a 4x8 instance for the hand-worked streams and a
// default-size instance for a long rotation against a bitwise model.
module tb_mem_rot_reader;

  logic clock;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Small instance: WIDTH=8, DEPTH=4
  logic       s_start, s_busy, s_done, s_valid, s_ready, s_last;
  logic [1:0] s_word_off, s_addr0, s_addr1;
  logic [2:0] s_bit_off;
  logic [7:0] s_q0, s_q1, s_out_data;
  logic [7:0] s_mem [4];

  mem_rot_reader #(.WIDTH(8), .DEPTH(4)) dut_s (
    .i_clock(clock), .i_rst_n(rst_n), .i_start(s_start),
    .i_word_off(s_word_off), .i_bit_off(s_bit_off),
    .o_busy(s_busy), .o_done(s_done),
    .o_rd_addr_0(s_addr0), .o_rd_addr_1(s_addr1),
    .i_rd_q_0(s_q0), .i_rd_q_1(s_q1),
    .o_out_data(s_out_data), .o_out_valid(s_valid),
    .i_out_ready(s_ready), .o_out_last(s_last)
  );

  always @(posedge clock) begin
    s_q0 <= s_mem[s_addr0];
    s_q1 <= s_mem[s_addr1];
  end

  // Large instance: default WIDTH=512, DEPTH=70
  logic         l_start, l_busy, l_done, l_valid, l_ready, l_last;
  logic [6:0]   l_word_off, l_addr0, l_addr1;
  logic [8:0]   l_bit_off;
  logic [511:0] l_q0, l_q1, l_out_data;
  logic [511:0] l_mem [70];

  mem_rot_reader dut_l (
    .i_clock(clock), .i_rst_n(rst_n), .i_start(l_start),
    .i_word_off(l_word_off), .i_bit_off(l_bit_off),
    .o_busy(l_busy), .o_done(l_done),
    .o_rd_addr_0(l_addr0), .o_rd_addr_1(l_addr1),
    .i_rd_q_0(l_q0), .i_rd_q_1(l_q1),
    .o_out_data(l_out_data), .o_out_valid(l_valid),
    .i_out_ready(l_ready), .o_out_last(l_last)
  );

  always @(posedge clock) begin
    l_q0 <= l_mem[l_addr0];
    l_q1 <= l_mem[l_addr1];
  end

  // Results captured by the stream drivers.
  logic [7:0]   s_got [$];
  logic         s_lastq [$];
  int           s_done_cnt, s_done_cyc, s_first_valid, s_stall_err;
  logic         s_busy_at_done, s_busy_after, s_timeout;
  logic [15:0]  s_rst_snap;
  logic [3:0]   s_addr_snap;
  logic [511:0] l_got [$];
  logic         l_lastq [$];
  int           l_done_cnt;
  logic         l_timeout;

  // Drive one small-instance stream, sampling on the falling edge.
  task automatic run_small(input logic [1:0] wo, input logic [2:0] bo,
                           input int ready_mode, input int restart_at,
                           input int reset_at);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       rdy;
    int         c;
    int         after;
    s_got.delete();
    s_lastq.delete();
    s_done_cnt = 0; s_done_cyc = -1; s_first_valid = -1; s_stall_err = 0;
    s_busy_at_done = 1'bx; s_busy_after = 1'bx; s_timeout = 1'b0;
    s_rst_snap = 'x;
    prev_stall = 1'b0; prev_data = '0; after = -1; c = 0;
    @(negedge clock);
    s_start = 1'b1; s_word_off = wo; s_bit_off = bo; s_ready = 1'b0;
    @(negedge clock);
    s_addr_snap = {s_addr0, s_addr1};
    while (1) begin
      if (c == restart_at) begin
        s_start = 1'b1; s_word_off = 2'd2;
      end else begin
        s_start = 1'b0;
      end
      if (reset_at >= 0 && c == reset_at) begin
        rst_n = 1'b0;
        #1;
        s_rst_snap = {s_busy, s_done, s_valid, s_last, s_out_data, s_addr0, s_addr1};
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        break;
      end
      rdy = (ready_mode == 0) ? 1'b1 : ((c % 3) == 0);
      s_ready = rdy;
      if (prev_stall && (!s_valid || s_out_data !== prev_data)) s_stall_err++;
      prev_stall = s_valid && !rdy;
      prev_data  = s_out_data;
      if (s_valid && s_first_valid < 0) s_first_valid = c;
      if (s_valid && rdy) begin
        s_got.push_back(s_out_data);
        s_lastq.push_back(s_last);
      end
      if (s_done) begin
        s_done_cnt++;
        if (s_done_cyc < 0) begin
          s_done_cyc = c;
          s_busy_at_done = s_busy;
        end
        after = c;
      end
      if (after >= 0 && c == after + 2) begin
        s_busy_after = s_busy;
        break;
      end
      if (c == 80) begin
        s_timeout = 1'b1;
        break;
      end
      c++;
      @(negedge clock);
    end
    s_start = 1'b0;
    s_ready = 1'b0;
  endtask

  task automatic run_large(input logic [6:0] wo, input logic [8:0] bo);
    int c;
    int after;
    l_got.delete();
    l_lastq.delete();
    l_done_cnt = 0; l_timeout = 1'b0; after = -1; c = 0;
    @(negedge clock);
    l_start = 1'b1; l_word_off = wo; l_bit_off = bo; l_ready = 1'b1;
    @(negedge clock);
    l_start = 1'b0;
    while (1) begin
      if (l_valid) begin
        l_got.push_back(l_out_data);
        l_lastq.push_back(l_last);
      end
      if (l_done) begin
        l_done_cnt++;
        after = c;
      end
      if (after >= 0 && c == after + 2) break;
      if (c == 400) begin
        l_timeout = 1'b1;
        break;
      end
      c++;
      @(negedge clock);
    end
    l_ready = 1'b0;
  endtask

  task automatic check_small_words(input string name, input logic [7:0] e0,
                                   input logic [7:0] e1, input logic [7:0] e2,
                                   input logic [7:0] e3);
    logic [7:0] exp_w [4];
    logic [7:0] obs;
    logic       obs_last;
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    n_vec++;
    if (s_got.size() !== 4 || s_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL %s word_count: got %0d (timeout %0b) expected 4", name, s_got.size(), s_timeout);
    end
    for (int i = 0; i < 4; i++) begin
      obs      = (i < s_got.size()) ? s_got[i] : 8'hxx;
      obs_last = (i < s_lastq.size()) ? s_lastq[i] : 1'bx;
      n_vec++;
      if (obs !== exp_w[i]) begin
        n_err++;
        $display("FAIL %s word%0d: got %h expected %h", name, i, obs, exp_w[i]);
      end
      n_vec++;
      if (obs_last !== (i == 3)) begin
        n_err++;
        $display("FAIL %s last%0d: got %b expected %b", name, i, obs_last, (i == 3));
      end
    end
    n_vec++;
    if (s_done_cnt !== 1) begin
      n_err++;
      $display("FAIL %s done_count: got %0d expected 1", name, s_done_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({s_busy, s_done, s_valid, s_last} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 0000", {s_busy, s_done, s_valid, s_last});
    end
    n_vec++;
    if (s_out_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 00", s_out_data);
    end
    n_vec++;
    if ({s_addr0, s_addr1} !== 4'h0) begin
      n_err++;
      $display("FAIL reset_addr: got %h expected 0", {s_addr0, s_addr1});
    end
    n_vec++;
    if ({l_busy, l_valid, l_out_data} !== '0) begin
      n_err++;
      $display("FAIL reset_large: got busy %b valid %b", l_busy, l_valid);
    end
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_small(2'd0, 3'd0, 0, -1, -1);
    check_small_words("basic", 8'h11, 8'h22, 8'h33, 8'h44);
    n_vec++;
    if (s_addr_snap !== 4'b0001) begin
      n_err++;
      $display("FAIL basic_addr: got %h expected 1", s_addr_snap);
    end
    n_vec++;
    if (s_first_valid !== 2) begin
      n_err++;
      $display("FAIL basic_latency: got %0d expected 2", s_first_valid);
    end
    n_vec++;
    if (s_done_cyc !== 6) begin
      n_err++;
      $display("FAIL basic_done_cycle: got %0d expected 6", s_done_cyc);
    end
    n_vec++;
    if (s_busy_at_done !== 1'b0 || s_busy_after !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy: got %b/%b expected 0/0", s_busy_at_done, s_busy_after);
    end
  endtask

  task automatic test_rotate_wrap();
    run_small(2'd3, 3'd4, 0, -1, -1);
    check_small_words("rotate", 8'h14, 8'h21, 8'h32, 8'h43);
    n_vec++;
    if (s_addr_snap !== 4'b1100) begin
      n_err++;
      $display("FAIL rotate_addr_wrap: got %h expected c", s_addr_snap);
    end
  endtask

  task automatic test_backpressure();
    run_small(2'd1, 3'd0, 1, -1, -1);
    check_small_words("backpressure", 8'h22, 8'h33, 8'h44, 8'h11);
    n_vec++;
    if (s_stall_err !== 0) begin
      n_err++;
      $display("FAIL backpressure_stable: got %0d changes expected 0", s_stall_err);
    end
  endtask

  task automatic test_start_ignored();
    run_small(2'd0, 3'd0, 0, 1, -1);
    check_small_words("start_ignored", 8'h11, 8'h22, 8'h33, 8'h44);
  endtask

  task automatic test_reset_midstream();
    run_small(2'd0, 3'd0, 0, -1, 3);
    n_vec++;
    if (s_rst_snap !== 16'h0000) begin
      n_err++;
      $display("FAIL midreset_outputs: got %h expected 0000", s_rst_snap);
    end
    n_vec++;
    if (s_got.size() !== 1 || s_done_cnt !== 0) begin
      n_err++;
      $display("FAIL midreset_abort: got %0d words %0d done expected 1 words 0 done", s_got.size(), s_done_cnt);
    end
    run_small(2'd2, 3'd0, 0, -1, -1);
    check_small_words("after_reset", 8'h33, 8'h44, 8'h11, 8'h22);
  endtask

  task automatic test_large();
    logic [511:0] exp_w;
    logic [511:0] obs;
    logic         obs_last;
    int           b;
    for (int w = 0; w < 70; w++)
      for (int i = 0; i < 16; i++)
        l_mem[w][32*i +: 32] = $urandom;
    run_large(7'd69, 9'd511);
    n_vec++;
    if (l_got.size() !== 70 || l_done_cnt !== 1 || l_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL large_count: got %0d words %0d done expected 70 words 1 done", l_got.size(), l_done_cnt);
    end
    for (int k = 0; k < 70; k++) begin
      for (int j = 0; j < 512; j++) begin
        b = ((69 + k) * 512 + 511 + j) % (70 * 512);
        exp_w[j] = l_mem[b / 512][b % 512];
      end
      obs      = (k < l_got.size()) ? l_got[k] : 'x;
      obs_last = (k < l_lastq.size()) ? l_lastq[k] : 1'bx;
      n_vec++;
      if (obs !== exp_w) begin
        n_err++;
        $display("FAIL large_word%0d: got %h expected %h", k, obs, exp_w);
      end
      n_vec++;
      if (obs_last !== (k == 69)) begin
        n_err++;
        $display("FAIL large_last%0d: got %b expected %b", k, obs_last, (k == 69));
      end
    end
  endtask

  initial begin
    s_start = 1'b0; s_word_off = '0; s_bit_off = '0; s_ready = 1'b0;
    l_start = 1'b0; l_word_off = '0; l_bit_off = '0; l_ready = 1'b0;
    s_mem[0] = 8'h11; s_mem[1] = 8'h22; s_mem[2] = 8'h33; s_mem[3] = 8'h44;
    for (int w = 0; w < 70; w++) l_mem[w] = '0;
    test_reset();
    test_basic();
    test_rotate_wrap();
    test_backpressure();
    test_start_ignored();
    test_reset_midstream();
    test_large();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_rot_reader.md
Name: mem_rot_reader

Overview:
- Read-side controller for the dual-read, single-write distributed polynomial memory. It streams a cyclically rotated copy of a stored polynomial (DEPTH words of WIDTH bits) out over a valid/ready interface.
- Rotation is by word offset plus bit offset. Both memory read ports are used: consecutive words are fetched in parallel and funnel-shifted into one output word.
- Serves the HQC multiply and encode datapaths, which consume cyclic shifts of stored vectors.

Parameters:
- WIDTH, 512, memory word width in bits; must match the attached memory.
- DEPTH, 70, number of words per polynomial; must match the attached memory.
- AW, `CLOG2(DEPTH), memory address width (derived, not overridden).
- BW, `CLOG2(WIDTH), bit-offset width (derived, not overridden).

Ports:
- clock  in  1  system clock; all state on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- word_off  in  AW  word rotation offset, 0..DEPTH-1; sampled on accepted start
- bit_off  in  BW  bit rotation offset, 0..WIDTH-1; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last output handshake
- rd_addr_0  out  AW  to memory address_0
- rd_addr_1  out  AW  to memory address_1
- rd_q_0  in  WIDTH  from memory q_0 (registered, 1-cycle latency)
- rd_q_1  in  WIDTH  from memory q_1 (registered, 1-cycle latency)
- out_data  out  WIDTH  rotated output word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when valid and ready are both high
- out_last  out  1  marks output word index DEPTH-1

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, out_valid=0, out_last=0, out_data=0, rd_addr_0=0, rd_addr_1=0; issue counter, credit counter and FIFO pointers cleared. Reset mid-stream aborts the stream with no done pulse.
- States:
  - IDLE: start moves to RUN and latches both offsets.
  - RUN: issue reads; wait for the last handshake, then go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
  - start in RUN or FIN is ignored.
- Output word k (0..DEPTH-1) is the WIDTH-bit slice starting at bit (word_off+k)*WIDTH + bit_off of the cyclic polynomial.
- Address issue, when a read is issued for k:
  - rd_addr_0 = (word_off+k) mod DEPTH
  - rd_addr_1 = (rd_addr_0+1) mod DEPTH
  - Wrap is by compare-and-subtract, never by power-of-two truncation. Address DEPTH-1 is followed by 0.
- Datapath per returned pair: out word = low WIDTH bits of ({rd_q_1, rd_q_0} >> bit_off). With bit_off=0 the result equals rd_q_0 exactly.
- Read latency: data for an issue in cycle t is sampled from rd_q_* in cycle t+1. The shifted word is then written into a 2-entry output FIFO.
- Flow control:
  - Credit counter = FIFO occupancy + reads in flight, range 0..2.
  - A read is issued in a cycle only if credit < 2, or credit = 2 and an output handshake occurs in that cycle.
  - Issue count never exceeds DEPTH.
  - The FIFO never overflows. Throughput is one word per cycle while out_ready=1.
- Output:
  - out_valid = FIFO non-empty; out_data is the FIFO head.
  - out_last = out_valid and head index = DEPTH-1.
  - Head is stable while out_valid=1 and out_ready=0.
- Completion: the handshake with out_last=1 moves RUN to FIN. busy drops in the same cycle done rises.
- The memory must not be written while busy. The memory returns write data on q_0 during writes, so mixing reads and writes corrupts the stream. This is not checked here.
- Offsets outside range (word_off >= DEPTH) are undefined; the bench must not drive them.
- Latency: first out_valid 2 cycles after the accepted start (address issue, memory read, FIFO write). Done arrives 1 cycle after the last handshake.

Test Plan:
- WIDTH=8, DEPTH=4, memory words 0x11,0x22,0x33,0x44; start with word_off=0, bit_off=0, out_ready=1 -> out 0x11,0x22,0x33,0x44 on consecutive cycles; out_last on 0x44; done 1 cycle later; busy low after.
- Same memory, word_off=3, bit_off=4 -> out 0x14,0x21,0x32,0x43 (wrap pairs (3,0),(0,1),(1,2),(2,3)).
- Same memory, word_off=1, bit_off=0, out_ready toggling 1,0,0,1,... -> words 0x22,0x33,0x44,0x11 each delivered exactly once, in order; out_data stable while stalled; credit never exceeds 2.
- Pulse start again while busy with word_off=2 -> ignored; the stream completes with the original offsets; a single done pulse.
- Deassert rst_n during the 2nd output word -> all outputs 0 immediately; new start after release produces a full correct 4-word stream.
- Default WIDTH=512, DEPTH=70, random memory, word_off=69, bit_off=511 -> 70 words matching the software rotation model; out_last only on the 70th word.
